// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the multi-port register file and its scoreboard.
package reg_file_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 32;
    localparam int unsigned DEF_NR       = 2;
    localparam int unsigned DEF_NW       = 2;
    localparam int unsigned ZERO_REG     = 0;

    function automatic int unsigned addr_w(input int unsigned num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking: issue sets, write-back clears, set wins on a same-cycle race.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NR       = DEF_NR,
    parameter int unsigned NW       = DEF_NW,
    parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NW-1:0]        reg_write,
    input  logic [NW*ADDR_W-1:0] write_reg,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_reg,
    input  logic [NR*ADDR_W-1:0] read_reg,
    output logic [NR-1:0]        read_busy
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] clr;

    always_comb begin
        clr = '0;
        for (int j = 0; j < int'(NW); j++) begin
            if (reg_write[j]) begin
                clr[write_reg[j*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d = busy_q & ~clr;
        if (issue_valid && issue_reg != ADDR_W'(ZERO_REG)) begin
            busy_d[issue_reg] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
        if (rst) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        busy_q <= busy_d;
    end

    // A register being written this cycle reads not-busy so it matches the bypassed data.
    for (genvar k = 0; k < NR; k++) begin : g_rd_busy
        logic [ADDR_W-1:0] ra;
        assign ra           = read_reg[k*ADDR_W +: ADDR_W];
        assign read_busy[k] = busy_q[ra] & ~clr[ra];
    end

endmodule

// File: rtl/reg_file_mp.sv
// NR-read / NW-write register file with same-cycle write-through bypass and a busy scoreboard.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NR       = DEF_NR,
    parameter int unsigned NW       = DEF_NW,
    parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NR*ADDR_W-1:0] read_reg,
    output logic [NR*DATA_W-1:0] read_data,
    output logic [NR-1:0]        read_busy,
    input  logic [NW-1:0]        reg_write,
    input  logic [NW*ADDR_W-1:0] write_reg,
    input  logic [NW*DATA_W-1:0] write_data,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_reg
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Later ports overwrite earlier ones, so the highest index wins a collision.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < int'(NW); j++) begin
            if (reg_write[j] && write_reg[j*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG)) begin
                regs_d[write_reg[j*ADDR_W +: ADDR_W]] = write_data[j*DATA_W +: DATA_W];
            end
        end
        regs_d[ZERO_REG] = '0;
        if (rst) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                regs_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        assign ra = read_reg[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = regs_q[ra];
            if (!rst) begin
                for (int j = 0; j < int'(NW); j++) begin
                    if (reg_write[j] && write_reg[j*ADDR_W +: ADDR_W] == ra) begin
                        rd = write_data[j*DATA_W +: DATA_W];
                    end
                end
            end
            if (ra == ADDR_W'(ZERO_REG)) begin
                rd = '0;
            end
        end

        assign read_data[k*DATA_W +: DATA_W] = rd;
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NR       (NR),
        .NW       (NW),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .read_reg    (read_reg),
        .read_busy   (read_busy)
    );

endmodule
